// File: rtl/pc_stack_pkg.sv
// Shared types and defaults for the program counter with return stack.
// Action decode lives here so the priority order is written down once.
package pc_stack_pkg;

`include "pc_defs.vh"

    localparam int PC_WIDTH_DEF = `PC_WIDTH;
    localparam int PC_DEPTH_DEF = `PC_DEPTH;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_CALL,
        ACT_RET,
        ACT_INC
    } pc_act_e;

    // Priority: load > call > ret > inc > hold.
    function automatic pc_act_e decode_act(input logic load,
                                           input logic call,
                                           input logic ret,
                                           input logic inc);
        pc_act_e act;
        if (load)      act = ACT_LOAD;
        else if (call) act = ACT_CALL;
        else if (ret)  act = ACT_RET;
        else if (inc)  act = ACT_INC;
        else           act = ACT_HOLD;
        return act;
    endfunction

endpackage

// File: rtl/pc_defs.vh
// Shared sizing for the program-counter, memory and register blocks.
`ifndef PC_DEFS_VH
`define PC_DEFS_VH

`define PC_WIDTH 16
`define PC_DEPTH 4
// Stack pointer needs one extra bit so that "full" (sp == DEPTH) is representable.
`define PC_SP_W(depth) ($clog2(depth) + 1)

`endif

// File: rtl/ret_stack.sv
// Return-address LIFO with stack pointer and full/empty flags.
// Latency: push/pop take effect at the next rising edge; dout shows the current top.
// Backpressure: push when full and pop when empty are ignored; the caller flags the error.
module ret_stack
    import pc_stack_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH_DEF,
    parameter int DEPTH = PC_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int SP_W  = `PC_SP_W(DEPTH);
    localparam int IDX_W = $clog2(DEPTH);

    logic [SP_W-1:0]  sp_q, sp_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign full   = (sp_q == SP_W'(DEPTH));
    assign empty  = (sp_q == '0);
    assign wr_idx = sp_q[IDX_W-1:0];
    // When empty this wraps to the last slot; the caller never consumes it then.
    assign rd_idx = wr_idx - IDX_W'(1);
    assign dout   = mem_q[rd_idx];

    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Contents are deliberately not reset; sp gates every read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with jump, increment, call and return via a small return stack.
// Latency: every action is visible on out one cycle after the sampling edge.
// Backpressure: none; overflow/underflow are dropped and latched in sticky stk_err.
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH_DEF,
    parameter int DEPTH = PC_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] out,
    output logic             stk_empty,
    output logic             stk_full,
    output logic             stk_err
);

    pc_act_e          act;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] pc_inc;
    logic             err_q, err_d;
    logic             push, pop;
    logic [WIDTH-1:0] stk_top;
    logic             stk_full_w, stk_empty_w;

    assign act    = decode_act(load, call, ret, inc);
    assign pc_inc = out_q + WIDTH'(1);

    always_comb begin
        out_d = out_q;
        err_d = err_q;
        push  = 1'b0;
        pop   = 1'b0;
        case (act)
            ACT_LOAD: out_d = in;
            ACT_CALL: begin
                if (stk_full_w) begin
                    err_d = 1'b1;
                end else begin
                    push  = 1'b1;
                    out_d = in;
                end
            end
            ACT_RET: begin
                if (stk_empty_w) begin
                    err_d = 1'b1;
                end else begin
                    pop   = 1'b1;
                    out_d = stk_top;
                end
            end
            ACT_INC:  out_d = pc_inc;
            default:  out_d = out_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            err_q <= err_d;
        end
    end

    ret_stack #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stk_top),
        .full  (stk_full_w),
        .empty (stk_empty_w)
    );

    assign out       = out_q;
    assign stk_empty = stk_empty_w;
    assign stk_full  = stk_full_w;
    assign stk_err   = err_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: expected states queued at drive time, popped after each edge.
module tb_pc_stack;

    typedef struct packed {
        logic [15:0] pc;
        logic        emp;
        logic        ful;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] in = '0;
    logic        load = 1'b0;
    logic        inc = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [15:0] out;
    logic        stk_empty;
    logic        stk_full;
    logic        stk_err;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    pc_stack #(.WIDTH(16), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .load      (load),
        .inc       (inc),
        .call      (call),
        .ret       (ret),
        .out       (out),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .stk_err   (stk_err)
    );

    always #5 clk = ~clk;

    task automatic expect_state(input logic [15:0] eo, input logic ee,
                                input logic ef, input logic eerr);
        exp_t e;
        e.pc  = eo;
        e.emp = ee;
        e.ful = ef;
        e.err = eerr;
        sb.push_back(e);
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        exp_t a;
        a = {out, stk_empty, stk_full, stk_err};
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s: scoreboard empty, observed out=%h emp=%b full=%b err=%b",
                   tag, a.pc, a.emp, a.ful, a.err);
        end else begin
            e = sb.pop_front();
            assert (a === e) else begin
                bad++;
                $error("FAIL %s: observed out=%h emp=%b full=%b err=%b, expected out=%h emp=%b full=%b err=%b",
                       tag, a.pc, a.emp, a.ful, a.err, e.pc, e.emp, e.ful, e.err);
            end
        end
    endtask

    task automatic step(input logic l, input logic c, input logic r, input logic i,
                        input logic [15:0] d, input logic [15:0] eo, input logic ee,
                        input logic ef, input logic eerr, input string tag);
        @(negedge clk);
        load = l;
        call = c;
        ret  = r;
        inc  = i;
        in   = d;
        expect_state(eo, ee, ef, eerr);
        @(posedge clk);
        #1;
        check_now(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        load = 1'b0;
        call = 1'b0;
        ret  = 1'b0;
        inc  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        expect_state(16'h0000, 1'b1, 1'b0, 1'b0);
        check_now(tag);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset("reset_async");

        // count up from reset
        step(0, 0, 0, 1, 16'h0, 16'h0001, 1, 0, 0, "inc1");
        step(0, 0, 0, 1, 16'h0, 16'h0002, 1, 0, 0, "inc2");
        step(0, 0, 0, 1, 16'h0, 16'h0003, 1, 0, 0, "inc3");
        step(0, 0, 0, 0, 16'hABCD, 16'h0003, 1, 0, 0, "hold");

        // single call / return
        step(1, 0, 0, 0, 16'h0005, 16'h0005, 1, 0, 0, "load5");
        step(0, 1, 0, 0, 16'h0100, 16'h0100, 0, 0, 0, "call100");
        step(0, 0, 0, 1, 16'h0, 16'h0101, 0, 0, 0, "call_inc1");
        step(0, 0, 0, 1, 16'h0, 16'h0102, 0, 0, 0, "call_inc2");
        step(0, 0, 1, 0, 16'h0, 16'h0006, 1, 0, 0, "ret6");

        // nested calls up to full, then overflow
        step(1, 0, 0, 0, 16'h000A, 16'h000A, 1, 0, 0, "loadA");
        step(0, 1, 0, 0, 16'h0010, 16'h0010, 0, 0, 0, "nest1");
        step(0, 1, 0, 0, 16'h0020, 16'h0020, 0, 0, 0, "nest2");
        step(0, 1, 0, 0, 16'h0030, 16'h0030, 0, 0, 0, "nest3");
        step(0, 1, 0, 0, 16'h0040, 16'h0040, 0, 1, 0, "nest4_full");
        step(0, 1, 0, 0, 16'h0050, 16'h0040, 0, 1, 1, "overflow");
        step(0, 0, 1, 0, 16'h0, 16'h0031, 0, 0, 1, "unwind1");
        step(0, 0, 1, 0, 16'h0, 16'h0021, 0, 0, 1, "unwind2");
        step(0, 0, 1, 0, 16'h0, 16'h0011, 0, 0, 1, "unwind3");
        step(0, 0, 1, 0, 16'h0, 16'h000B, 1, 0, 1, "unwind4");

        // underflow, sticky error does not block later ops
        do_reset("reset2");
        step(0, 0, 1, 0, 16'h0, 16'h0000, 1, 0, 1, "underflow");
        step(0, 0, 0, 1, 16'h0, 16'h0001, 1, 0, 1, "inc_after_err");

        // priority and wrap
        do_reset("reset3");
        step(1, 0, 0, 0, 16'h0200, 16'h0200, 1, 0, 0, "load200");
        step(0, 1, 0, 0, 16'h0050, 16'h0050, 0, 0, 0, "call50");
        step(1, 1, 0, 0, 16'h1234, 16'h1234, 0, 0, 0, "load_over_call");
        step(1, 0, 1, 0, 16'h3000, 16'h3000, 0, 0, 0, "load_over_ret");
        step(0, 0, 1, 0, 16'h0, 16'h0201, 1, 0, 0, "ret_untouched");
        step(1, 0, 1, 0, 16'h4000, 16'h4000, 1, 0, 0, "load_ret_empty_noerr");
        step(0, 1, 1, 1, 16'h0077, 16'h0077, 0, 0, 0, "call_over_ret");
        step(0, 0, 1, 1, 16'h0, 16'h4001, 1, 0, 0, "ret_over_inc");
        step(1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 1, 0, 0, "loadFFFF");
        step(0, 0, 0, 1, 16'h0, 16'h0000, 1, 0, 0, "inc_wrap");

        // reset dropped between edges during a call sequence
        step(1, 0, 0, 0, 16'h0010, 16'h0010, 1, 0, 0, "pre_load");
        step(0, 1, 0, 0, 16'h0040, 16'h0040, 0, 0, 0, "pre_call");
        @(negedge clk);
        load = 1'b0;
        call = 1'b1;
        in   = 16'h0080;
        #2 rst_n = 1'b0;
        #1;
        expect_state(16'h0000, 1'b1, 1'b0, 1'b0);
        check_now("midcall_reset");
        @(posedge clk);
        #1;
        expect_state(16'h0000, 1'b1, 1'b0, 1'b0);
        check_now("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        call  = 1'b0;
        inc   = 1'b1;
        expect_state(16'h0001, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_now("first_edge_after_reset");

        @(negedge clk);
        inc = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter WIDTH, default 16, is the data width of the counter and the stack entries.
REQ-002 Parameter DEPTH, default 4, is the number of return-stack entries; it SHALL be a power of two and at least 2.
REQ-003 clk  input  1  Single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  Reset, asynchronous and active-low.
REQ-005 in  input  WIDTH  Jump or call target address.
REQ-006 load  input  1  Jump: out <= in.
REQ-007 inc  input  1  Advance: out <= out + 1.
REQ-008 call  input  1  Push out+1 onto the stack, then out <= in.
REQ-009 ret  input  1  Pop the stack top into out.
REQ-010 out  output  WIDTH  Current program counter; feeds the instruction-memory address and the downstream instruction register.
REQ-011 stk_empty  output  1  Stack holds 0 entries.
REQ-012 stk_full  output  1  Stack holds DEPTH entries.
REQ-013 stk_err  output  1  Sticky error flag for overflow or underflow.

Function
REQ-014 Controls SHALL be sampled at the rising edge of clk, with priority load > call > ret > inc > hold; at most one action executes per cycle.
REQ-015 With no control asserted, out and the stack SHALL hold.
REQ-016 inc SHALL wrap modulo 2^WIDTH (0xFFFF -> 0x0000).
REQ-017 call when not full: stack[sp] <= out+1 (wrapping), sp <= sp+1, out <= in; all three in the same edge.
REQ-018 call when full: out, sp and contents unchanged; stk_err <= 1.
REQ-019 ret when not empty: out <= stack[sp-1], sp <= sp-1.
REQ-020 ret when empty: out and sp unchanged; stk_err <= 1.
REQ-021 load SHALL NOT touch the stack, even when call or ret is asserted in the same cycle.
REQ-022 out, stk_empty, stk_full and stk_err SHALL be registered or derived only from registered sp; there is no combinational path from inputs to outputs.
REQ-023 Latency: every action is visible on out one cycle after the sampling edge.
REQ-024 The sp counter SHALL be log2(DEPTH)+1 bits wide; stk_full = (sp == DEPTH) and stk_empty = (sp == 0).
REQ-025 stk_err SHALL stay 1 until reset and SHALL NOT block later valid operations.

Reset
REQ-026 When rst_n = 0, the block SHALL immediately, without waiting for clk, drive out = 0, sp = 0, stk_empty = 1, stk_full = 0 and stk_err = 0.
REQ-027 Stack contents need no reset; they SHALL never reach out while empty.
REQ-028 Reset asserted mid-operation SHALL abort any pending action; the first edge after rst_n rises SHALL act on the inputs sampled at that edge.

Structure
REQ-029 WIDTH and DEPTH defaults, and the sp width derivation, SHALL live in a shared include file, pc_defs.vh, that is reused by the memory and register blocks.
REQ-030 The LIFO storage, sp and the full/empty logic SHALL be one sub-module, ret_stack, with ports push, pop, din, dout, full and empty.
REQ-031 pc_stack SHALL contain only the priority decode, the out register, the incrementer and the error flag.

Verification
REQ-032 Reset then inc for 3 cycles -> out = 0, 1, 2, 3; stk_empty = 1.
REQ-033 Sequence: out = 0x0005, call with in = 0x0100, then inc twice, then ret -> out = 0x0100, 0x0101, 0x0102, 0x0006; stk_empty = 1 at the end.
REQ-034 Four nested calls (in = 0x10, 0x20, 0x30, 0x40), then a fifth call with in = 0x50 -> stk_full = 1, out stays 0x40, stk_err = 1; then four rets -> out = 0x31, 0x21, 0x11, start+1.
REQ-035 ret right after reset -> out = 0, stk_err = 1; a later inc -> out = 1, stk_err is still 1.
REQ-036 load = 1 and call = 1 with in = 0x1234 -> out = 0x1234 and the stack is unchanged; load to 0xFFFF then inc -> out = 0x0000.
REQ-037 Drop rst_n between clock edges during a call sequence -> out = 0 and stk_empty = 1 before the next edge.
